// File: rtl/vga_text_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_text_timing
//  Purpose  : Parametrised VGA raster timing generator with a character-grid
//             text-window decoder (char column/row and glyph pixel/line).
//  Config   : VGA_TEXT_BLINK_EN - when defined, adds a frame counter that
//             toggles blink_o every BLINK_FRAMES frames; otherwise blink_o = 0.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_text_timing #(
   parameter int H_VISIBLE    = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_VISIBLE    = 400,
   parameter int V_FP         = 12,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 35,
   parameter bit H_SYNC_POL   = 1'b0,
   parameter bit V_SYNC_POL   = 1'b1,
   parameter int WIN_X0       = 316,
   parameter int WIN_Y0       = 192,
   parameter int COLS         = 1,
   parameter int ROWS         = 1,
   parameter int CHAR_W       = 8,
   parameter int CHAR_H       = 16,
   parameter int XW           = 10,
   parameter int YW           = 10,
   parameter int CW           = 7,
   parameter int RW           = 6,
   parameter int GXW          = 3,
   parameter int GYW          = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pix_ce_i,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           active_o,
   output logic [XW-1:0]  x_o,
   output logic [YW-1:0]  y_o,
   output logic           in_window_o,
   output logic [CW-1:0]  char_col_o,
   output logic [RW-1:0]  char_row_o,
   output logic [GXW-1:0] glyph_x_o,
   output logic [GYW-1:0] glyph_y_o,
   output logic           line_start_o,
   output logic           frame_start_o,
   output logic           blink_o
);

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST = H_VISIBLE + H_FP;
   localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
   localparam int VS_FIRST = V_VISIBLE + V_FP;
   localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
   localparam int WX_LAST  = WIN_X0 + COLS * CHAR_W - 1;
   localparam int WY_LAST  = WIN_Y0 + ROWS * CHAR_H - 1;

   // Raster position that will be reported on the next pix_ce cycle
   logic [XW-1:0]  h_q,  h_d;
   logic [YW-1:0]  v_q,  v_d;
   // Window sub-counters, valid for the current (h_q, v_q)
   logic [GXW-1:0] gx_q, gx_d;
   logic [CW-1:0]  cc_q, cc_d;
   logic [GYW-1:0] gy_q, gy_d;
   logic [RW-1:0]  cr_q, cr_d;

   // Registered outputs
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           active_q, active_d;
   logic [XW-1:0]  x_q;
   logic [YW-1:0]  y_q;
   logic           in_window_q, in_window_d;
   logic [CW-1:0]  char_col_q, char_col_d;
   logic [RW-1:0]  char_row_q, char_row_d;
   logic [GXW-1:0] glyph_x_q, glyph_x_d;
   logic [GYW-1:0] glyph_y_q, glyph_y_d;
   logic           line_start_q, line_start_d;
   logic           frame_start_q, frame_start_d;

   int   w_h;
   int   w_v;
   logic w_h_wrap;
   logic w_v_last;
   logic w_x_in;
   logic w_y_in;

   assign w_h      = int'(h_q);
   assign w_v      = int'(v_q);
   assign w_h_wrap = (w_h == H_TOTAL - 1);
   assign w_v_last = (w_v == V_TOTAL - 1);
   assign w_x_in   = (w_h >= WIN_X0) && (w_h <= WX_LAST);
   assign w_y_in   = (w_v >= WIN_Y0) && (w_v <= WY_LAST);

   // Next raster position: h wraps into v, v wraps on the same edge
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_ce_i) begin
         if (w_h_wrap) begin
            h_d = '0;
            v_d = w_v_last ? '0 : v_q + YW'(1);
         end else begin
            h_d = h_q + XW'(1);
         end
      end
   end

   // Character/glyph sub-counters stepped alongside h/v, zero outside the range
   always_comb begin
      gx_d = gx_q;
      cc_d = cc_q;
      gy_d = gy_q;
      cr_d = cr_q;
      if (pix_ce_i) begin
         // Next pixel still inside the X range: step glyph_x, carry into char_col
         if (w_x_in && !w_h_wrap && (w_h != WX_LAST)) begin
            if (int'(gx_q) == CHAR_W - 1) begin
               gx_d = '0;
               cc_d = cc_q + CW'(1);
            end else begin
               gx_d = gx_q + GXW'(1);
            end
         end else begin
            gx_d = '0;
            cc_d = '0;
         end
         // Vertical pair only moves at the end of a line
         if (w_h_wrap) begin
            if (w_y_in && !w_v_last && (w_v != WY_LAST)) begin
               if (int'(gy_q) == CHAR_H - 1) begin
                  gy_d = '0;
                  cr_d = cr_q + RW'(1);
               end else begin
                  gy_d = gy_q + GYW'(1);
               end
            end else begin
               gy_d = '0;
               cr_d = '0;
            end
         end
      end
   end

   // Output decode for the current position; registered on the next pix_ce edge
   always_comb begin
      hsync_d       = ((w_h >= HS_FIRST) && (w_h <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d       = ((w_v >= VS_FIRST) && (w_v <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
      active_d      = (w_h < H_VISIBLE) && (w_v < V_VISIBLE);
      in_window_d   = active_d && w_x_in && w_y_in;
      char_col_d    = in_window_d ? cc_q : '0;
      char_row_d    = in_window_d ? cr_q : '0;
      glyph_x_d     = in_window_d ? gx_q : '0;
      glyph_y_d     = in_window_d ? gy_q : '0;
      line_start_d  = pix_ce_i && (w_h == 0);
      frame_start_d = line_start_d && (w_v == 0);
   end

   // Position and sub-counter state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q  <= '0;
         v_q  <= '0;
         gx_q <= '0;
         cc_q <= '0;
         gy_q <= '0;
         cr_q <= '0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         gx_q <= gx_d;
         cc_q <= cc_d;
         gy_q <= gy_d;
         cr_q <= cr_d;
      end
   end

   // Output registers: levels hold without pix_ce, pulses clear every clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         active_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         in_window_q   <= 1'b0;
         char_col_q    <= '0;
         char_row_q    <= '0;
         glyph_x_q     <= '0;
         glyph_y_q     <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         if (pix_ce_i) begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            x_q         <= h_q;
            y_q         <= v_q;
            in_window_q <= in_window_d;
            char_col_q  <= char_col_d;
            char_row_q  <= char_row_d;
            glyph_x_q   <= glyph_x_d;
            glyph_y_q   <= glyph_y_d;
         end
      end
   end

`ifdef VGA_TEXT_BLINK_EN
   localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BFW-1:0] bcnt_q, bcnt_d;
   logic           blink_q, blink_d;

   // Frame counter steps on each frame start; blink flips when it wraps
   always_comb begin
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
      if (frame_start_d) begin
         if (int'(bcnt_q) >= BLINK_FRAMES - 1) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            bcnt_d = bcnt_q + BFW'(1);
         end
      end
   end

   // Blink state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         blink_q <= blink_d;
      end
   end

   assign blink_o = blink_q;
`else
   // No blink logic: constant 0 for any legal BLINK_FRAMES
   assign blink_o = (BLINK_FRAMES < 0);
`endif

   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign active_o      = active_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign in_window_o   = in_window_q;
   assign char_col_o    = char_col_q;
   assign char_row_o    = char_row_q;
   assign glyph_x_o     = glyph_x_q;
   assign glyph_y_o     = glyph_y_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_text_timing
//  Purpose  : Self-checking bench for vga_text_timing. Two instances with a
//             small raster (32x19), one with an interior text window and one
//             whose window is clipped by the visible area, compared every
//             cycle against an arithmetic model of the raster position.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_text_timing;

   localparam int HV = 20, HF = 3, HS = 4, HB = 5, HT = HV + HF + HS + HB;
   localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int CHW = 4, CHH = 3, NC = 3, NR = 2, BF = 2;
   localparam int AX0 = 5,  AY0 = 3;
   localparam int BX0 = 14, BY0 = 9;
`ifdef VGA_TEXT_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic pix_ce = 1'b1;

   logic       hs_a, vs_a, act_a, inw_a, ls_a, fs_a, bl_a;
   logic [5:0] x_a;
   logic [4:0] y_a;
   logic [1:0] cc_a, cr_a, gx_a, gy_a;
   logic       hs_b, vs_b, act_b, inw_b, ls_b, fs_b, bl_b;
   logic [5:0] x_b;
   logic [4:0] y_b;
   logic [1:0] cc_b, cr_b, gx_b, gy_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_text_timing #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1),
      .WIN_X0(AX0), .WIN_Y0(AY0), .COLS(NC), .ROWS(NR), .CHAR_W(CHW), .CHAR_H(CHH),
      .XW(6), .YW(5), .CW(2), .RW(2), .GXW(2), .GYW(2), .BLINK_FRAMES(BF)
   ) u_a (
      .clk(clk), .reset(reset), .pix_ce_i(pix_ce),
      .hsync_o(hs_a), .vsync_o(vs_a), .active_o(act_a), .x_o(x_a), .y_o(y_a),
      .in_window_o(inw_a), .char_col_o(cc_a), .char_row_o(cr_a),
      .glyph_x_o(gx_a), .glyph_y_o(gy_a), .line_start_o(ls_a),
      .frame_start_o(fs_a), .blink_o(bl_a)
   );

   vga_text_timing #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
      .WIN_X0(BX0), .WIN_Y0(BY0), .COLS(NC), .ROWS(NR), .CHAR_W(CHW), .CHAR_H(CHH),
      .XW(6), .YW(5), .CW(2), .RW(2), .GXW(2), .GYW(2), .BLINK_FRAMES(BF)
   ) u_b (
      .clk(clk), .reset(reset), .pix_ce_i(pix_ce),
      .hsync_o(hs_b), .vsync_o(vs_b), .active_o(act_b), .x_o(x_b), .y_o(y_b),
      .in_window_o(inw_b), .char_col_o(cc_b), .char_row_o(cr_b),
      .glyph_x_o(gx_b), .glyph_y_o(gy_b), .line_start_o(ls_b),
      .frame_start_o(fs_b), .blink_o(bl_b)
   );

   // Model state: linear count of pix_ce cycles since reset release
   bit m_has;
   int m_rep;
   int m_nxt;
   bit m_last_ce;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_has     <= 1'b0;
         m_rep     <= 0;
         m_nxt     <= 0;
         m_last_ce <= 1'b0;
      end else if (pix_ce) begin
         m_has     <= 1'b1;
         m_rep     <= m_nxt;
         m_nxt     <= m_nxt + 1;
         m_last_ce <= 1'b1;
      end else begin
         m_last_ce <= 1'b0;
      end
   end

   function automatic logic [38:0] pack(input logic hs, vs, act, input logic [7:0] x, y,
                                        input logic inw, input logic [3:0] cc, cr, gx, gy,
                                        input logic ls, fs, bl);
      return {hs, vs, act, x, y, inw, cc, cr, gx, gy, ls, fs, bl};
   endfunction

   // Expected outputs from the position count by plain arithmetic
   function automatic logic [38:0] model(input bit hp, input bit vp, input int wx0, input int wy0);
      int h, v, cc, cr, gx, gy;
      bit act, inw, hsv, vsv, ls, fs, bl;
      if (!m_has) return pack(~hp, ~vp, 1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      h   = m_rep % HT;
      v   = (m_rep / HT) % VT;
      act = (h < HV) && (v < VV);
      hsv = (h >= HV + HF && h < HV + HF + HS) ? hp : ~hp;
      vsv = (v >= VV + VF && v < VV + VF + VS) ? vp : ~vp;
      inw = act && h >= wx0 && h < wx0 + NC * CHW && v >= wy0 && v < wy0 + NR * CHH;
      cc = 0; cr = 0; gx = 0; gy = 0;
      if (inw) begin
         cc = (h - wx0) / CHW;  gx = (h - wx0) % CHW;
         cr = (v - wy0) / CHH;  gy = (v - wy0) % CHH;
      end
      ls = m_last_ce && (h == 0);
      fs = ls && (v == 0);
      bl = BLINK_ON ? (((m_rep / FRAME + 1) / BF) % 2 == 1) : 1'b0;
      return pack(hsv, vsv, act, 8'(h), 8'(v), inw, 4'(cc), 4'(cr), 4'(gx), 4'(gy), ls, fs, bl);
   endfunction

   // Every-cycle comparison of both instances against the model
   initial begin
      logic [38:0] e, a;
      forever begin
         @(negedge clk);
         e = model(1'b0, 1'b1, AX0, AY0);
         a = pack(hs_a, vs_a, act_a, 8'(x_a), 8'(y_a), inw_a, 4'(cc_a), 4'(cr_a),
                  4'(gx_a), 4'(gy_a), ls_a, fs_a, bl_a);
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle_a t=%0t got=%h expected=%h", $time, a, e);
         end
         e = model(1'b1, 1'b0, BX0, BY0);
         a = pack(hs_b, vs_b, act_b, 8'(x_b), 8'(y_b), inw_b, 4'(cc_b), 4'(cr_b),
                  4'(gx_b), 4'(gy_b), ls_b, fs_b, bl_b);
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle_b t=%0t got=%h expected=%h", $time, a, e);
         end
      end
   end

   // Frame length and window area measured between frame_start pulses
   int cyc = 0, last_fs = -1, frame_len = 0;
   int win_a = 0, win_b = 0, win_last_a = 0, win_last_b = 0;
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (fs_a === 1'b1) begin
            if (last_fs >= 0) frame_len = cyc - last_fs;
            last_fs    = cyc;
            win_last_a = win_a;
            win_last_b = win_b;
            win_a      = 0;
            win_b      = 0;
         end
         if (inw_a === 1'b1) win_a++;
         if (inw_b === 1'b1) win_b++;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // mode 0: ce always 1, mode 1: ce toggles, mode 2: random ce (75% high)
   task automatic run(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         case (mode)
            0:       pix_ce = 1'b1;
            1:       pix_ce = ~pix_ce;
            default: pix_ce = ($urandom_range(0, 3) != 0);
         endcase
      end
   endtask

   task automatic wait_pos(input int wx, input int wy, input int mode, input int bound, input string tag);
      int n = 0;
      while (!((int'(x_a) == wx) && (wy < 0 || int'(y_a) == wy)) && n < bound) begin
         run(1, mode);
         n++;
      end
      if (n >= bound) begin
         total++;
         bad++;
         $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles", tag, wx, wy, bound);
      end
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_hsync_a", 32'(hs_a), 1);
      check("reset_vsync_a", 32'(vs_a), 0);
      check("reset_hsync_b", 32'(hs_b), 0);
      check("reset_active_a", 32'(act_a), 0);

      reset  = 1'b0;
      pix_ce = 1'b1;
      @(negedge clk);
      check("first_x", 32'(x_a), 0);
      check("first_y", 32'(y_a), 0);
      check("first_active", 32'(act_a), 1);
      check("first_frame_start", 32'(fs_a), 1);

      run(2 * FRAME + 10, 0);
      check("frame_len_ce1", frame_len, FRAME);
      check("window_area_a", win_last_a, NC * CHW * NR * CHH);
      check("window_area_b_clipped", win_last_b, 18);

      wait_pos(HV + HF - 1, -1, 0, 100, "hsync_pos");
      check("hsync_before", 32'(hs_a), 1);
      run(1, 0);
      check("hsync_first_x", 32'(x_a), HV + HF);
      check("hsync_first", 32'(hs_a), 0);
      check("hsync_first_b", 32'(hs_b), 1);
      wait_pos(0, VV + VF, 0, 2 * FRAME, "vsync_pos");
      check("vsync_a", 32'(vs_a), 1);
      check("vsync_b", 32'(vs_b), 0);

      run(3 * 2 * FRAME + 4, 1);
      check("frame_len_ce_toggle", frame_len, 2 * FRAME);

      run(5000, 2);

      wait_pos(15, 7, 2, 4000, "reset_pos");
      #2 reset = 1'b1;
      #1;
      check("async_x", 32'(x_a), 0);
      check("async_y", 32'(y_a), 0);
      check("async_active", 32'(act_a), 0);
      check("async_in_window", 32'(inw_a), 0);
      check("async_glyph_x", 32'(gx_a), 0);
      check("async_hsync", 32'(hs_a), 1);
      check("async_blink", 32'(bl_a), 0);
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      pix_ce = 1'b1;
      @(negedge clk);
      check("restart_x", 32'(x_a), 0);
      check("restart_y", 32'(y_a), 0);
      check("restart_frame_start", 32'(fs_a), 1);

      run(2000, 2);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
